// File: rtl/bytebeat_pwm.sv
// -----------------------------------------------------------------------------
// bytebeat_pwm
//
// Turns a stream of 8-bit bytebeat samples into a single-bit PWM audio output.
// Each PWM period is 256 steps of DIV clocks. At the end of every period the
// time index t advances and sample_req pulses so the upstream bytebeat
// generators can compute the next sample for the new t. A sample that arrives
// during a period is parked in a shadow register and becomes the active duty
// value at the next period boundary.
//
// Parameters
//   DIV  clocks per PWM step (1..255)
//   TW   width of the bytebeat time counter t
//
// Ports
//   wb_clk_i      in   clock; every register updates on its rising edge
//   wb_rst_i      in   synchronous active-high reset, overrides everything
//   en            in   run enable; 0 parks the PWM counters at step 0
//   sample[7:0]   in   selected bytebeat sample
//   sample_valid  in   sample is meaningful this cycle
//   clr_flags     in   one-cycle pulse clearing underrun/overrun
//   t[TW-1:0]     out  bytebeat time index
//   sample_req    out  one-cycle pulse after each period end (t advanced)
//   pwm_out       out  registered PWM audio bit
//   underrun      out  sticky: a period ended with no fresh sample pending
//   overrun       out  sticky: a pending sample was overwritten unused
// -----------------------------------------------------------------------------
module bytebeat_pwm #(
    parameter int DIV = 4,
    parameter int TW  = 19
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          en,
    input  logic [7:0]    sample,
    input  logic          sample_valid,
    input  logic          clr_flags,
    output logic [TW-1:0] t,
    output logic          sample_req,
    output logic          pwm_out,
    output logic          underrun,
    output logic          overrun
);

    // Last prescaler value of a PWM step. DIV is at most 255, so eight bits
    // are always enough for the prescaler.
    localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

    // Flag indices for the sticky flag generate loop.
    localparam int FLAG_UNDERRUN = 0;
    localparam int FLAG_OVERRUN  = 1;
    localparam int NUM_FLAGS     = 2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0]    presc_reg,   presc_next;
    logic [7:0]    cnt_reg,     cnt_next;
    logic [TW-1:0] t_reg,       t_next;
    logic [7:0]    active_reg,  active_next;
    logic [7:0]    shadow_reg,  shadow_next;
    logic          pending_reg, pending_next;
    logic          pwm_reg,     pwm_next;
    logic          sreq_reg,    sreq_next;

    logic                 presc_last;
    logic                 period_end;
    logic [NUM_FLAGS-1:0] flag_set;
    logic [NUM_FLAGS-1:0] flags;

    // -------------------------------------------------------------------------
    // Period timing
    //
    // The run/idle mode is simply en: the first clock with en=1 is already
    // step 0 (the counters were parked at zero while idle), and the first
    // clock with en=0 returns the counters to zero at that same edge. There
    // is therefore no separate mode register to lag behind en.
    // -------------------------------------------------------------------------
    assign presc_last = (presc_reg == PRESC_LAST);
    assign period_end = en && presc_last && (cnt_reg == 8'hFF);

    always_comb begin
        presc_next = 8'd0;
        cnt_next   = 8'd0;
        if (en) begin
            if (presc_last) begin
                presc_next = 8'd0;
                cnt_next   = cnt_reg + 8'd1;    // wraps 255 -> 0
            end else begin
                presc_next = presc_reg + 8'd1;
                cnt_next   = cnt_reg;
            end
        end
    end

    // t only moves at a period boundary; it is held while idle.
    always_comb begin
        t_next = t_reg;
        if (period_end) begin
            t_next = t_reg + TW'(1);            // wraps all-ones -> 0
        end
    end

    // -------------------------------------------------------------------------
    // PWM compare and request pulse
    //
    // The compare uses the pre-edge step and duty, so pwm_out trails the step
    // counter by one clock. With duty 0xFF the last step (255) is still low,
    // which gives 255 high steps out of 256.
    // -------------------------------------------------------------------------
    assign pwm_next  = en && (cnt_reg < active_reg);
    assign sreq_next = period_end;

    // -------------------------------------------------------------------------
    // Sample double buffer
    //
    // shadow captures every valid sample, in run and idle alike, and never
    // looks at sample when sample_valid is low. At a period boundary the
    // pre-edge shadow is promoted to active if a sample was pending. A sample
    // that lands exactly on the boundary cycle goes into shadow and keeps
    // pending set, so it is used one period later rather than being lost.
    // -------------------------------------------------------------------------
    always_comb begin
        shadow_next = shadow_reg;
        if (sample_valid) begin
            shadow_next = sample;
        end
    end

    always_comb begin
        active_next = active_reg;
        if (period_end && pending_reg) begin
            active_next = shadow_reg;
        end
    end

    assign pending_next = sample_valid || (pending_reg && !period_end);

    // -------------------------------------------------------------------------
    // Sticky flag set conditions
    //   underrun: boundary reached with nothing pending; duty is kept.
    //   overrun : a pending sample replaced mid-period. On the boundary
    //             cycle the old shadow is being consumed, so that is not an
    //             overrun.
    // -------------------------------------------------------------------------
    assign flag_set[FLAG_UNDERRUN] = period_end && !pending_reg;
    assign flag_set[FLAG_OVERRUN]  = sample_valid && pending_reg && !period_end;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc_reg   <= 8'd0;
            cnt_reg     <= 8'd0;
            t_reg       <= '0;
            active_reg  <= 8'd0;
            shadow_reg  <= 8'd0;
            pending_reg <= 1'b0;
            pwm_reg     <= 1'b0;
            sreq_reg    <= 1'b0;
        end else begin
            presc_reg   <= presc_next;
            cnt_reg     <= cnt_next;
            t_reg       <= t_next;
            active_reg  <= active_next;
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
            pwm_reg     <= pwm_next;
            sreq_reg    <= sreq_next;
        end
    end

    // Sticky flags: a set condition on the same edge as clr_flags wins, so an
    // event is never lost to a clear that happened to coincide with it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            logic flag_reg;

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    flag_reg <= 1'b0;
                end else begin
                    flag_reg <= (flag_reg && !clr_flags) || flag_set[gi];
                end
            end

            assign flags[gi] = flag_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign t          = t_reg;
    assign sample_req = sreq_reg;
    assign pwm_out    = pwm_reg;
    assign underrun   = flags[FLAG_UNDERRUN];
    assign overrun    = flags[FLAG_OVERRUN];

endmodule

// File: tb/tb_bytebeat_pwm.sv
// -----------------------------------------------------------------------------
// tb_bytebeat_pwm
//
// dut1: DIV=1, TW=4 so the full 256-clock period and the t wrap are reachable
//       in a few thousand clocks. A table of per-period records drives sample
//       events and clears; the expected duty count, t and flags for each period
//       are pushed to a scoreboard queue and popped when sample_req appears.
// dut2: DIV=3, default TW; checks the prescaler stretches the period to 768
//       clocks and the duty to 3 clocks per step.
// -----------------------------------------------------------------------------
module tb_bytebeat_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       en2;
    logic [7:0] sample;
    logic       sample_valid;
    logic       clr_flags;

    logic [3:0]  t1;
    logic        sreq1, pwm1, ur1, ov1;
    logic [18:0] t2;
    logic        sreq2, pwm2, ur2, ov2;

    bytebeat_pwm #(.DIV(1), .TW(4)) dut1 (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .en          (en),
        .sample      (sample),
        .sample_valid(sample_valid),
        .clr_flags   (clr_flags),
        .t           (t1),
        .sample_req  (sreq1),
        .pwm_out     (pwm1),
        .underrun    (ur1),
        .overrun     (ov1)
    );

    bytebeat_pwm #(.DIV(3), .TW(19)) dut2 (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .en          (en2),
        .sample      (sample),
        .sample_valid(sample_valid),
        .clr_flags   (clr_flags),
        .t           (t2),
        .sample_req  (sreq2),
        .pwm_out     (pwm2),
        .underrun    (ur2),
        .overrun     (ov2)
    );

    // One period of stimulus plus its expected outcome (-1 step = no event).
    typedef struct {
        int         ev0_step;
        logic [7:0] ev0_val;
        int         ev1_step;
        logic [7:0] ev1_val;
        int         clr_step;
        int         exp_hi;
        int         exp_ur;
        int         exp_ov;
    } vec_t;

    typedef struct {
        int hi;
        int t;
        int ur;
        int ov;
        int len;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    int checks  = 0;
    int passed  = 0;
    int hi_acc  = 0;
    int len_acc = 0;
    int t_model = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int hi, input int tv, input int ur, input int ov);
        exp_t e;
        e.hi  = hi;
        e.t   = tv;
        e.ur  = ur;
        e.ov  = ov;
        e.len = 256;
        sb.push_back(e);
    endtask

    // Advance one clock and observe dut1 one time unit after the edge. Every
    // observation contributes to the running duty count; a sample_req closes
    // the period and is compared against the oldest scoreboard entry.
    task automatic tick();
        @(posedge clk);
        #1;
        len_acc++;
        hi_acc += int'(pwm1);
        if (sreq1) begin
            if (sb.size() == 0) begin
                check("unexpected_sample_req", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("period_len", len_acc, e.len);
                check("duty_highs", hi_acc, e.hi);
                check("t_after_period", int'(t1), e.t);
                check("underrun", int'(ur1), e.ur);
                check("overrun", int'(ov1), e.ov);
                $display("period done: t=%0d highs=%0d len=%0d ur=%0d ov=%0d",
                         t1, hi_acc, len_acc, ur1, ov1);
            end
            hi_acc  = 0;
            len_acc = 0;
        end
    endtask

    initial begin
        int n;
        int m;
        int highs;

        //            ev0     val    ev1   val    clr  hi  ur ov
        vecs[0]  = '{ 10, 8'h40,  -1, 8'h00,  -1,   0, 0, 0};
        vecs[1]  = '{ -1, 8'h00,  -1, 8'h00,  -1,  64, 1, 0};
        vecs[2]  = '{  0, 8'hFF,  -1, 8'h00,   5,  64, 0, 0};
        vecs[3]  = '{ -1, 8'h00,  -1, 8'h00,  -1, 255, 1, 0};
        vecs[4]  = '{ -1, 8'h00,  -1, 8'h00, 255, 255, 1, 0};
        vecs[5]  = '{  3, 8'h00,  -1, 8'h00,  -1, 255, 1, 0};
        vecs[6]  = '{  2, 8'h10, 100, 8'h20,  -1,   0, 1, 1};
        vecs[7]  = '{ 20, 8'h50, 255, 8'h30,   1,  32, 0, 0};
        vecs[8]  = '{ -1, 8'h00,  -1, 8'h00,  -1,  80, 0, 0};
        vecs[9]  = '{ -1, 8'h00,  -1, 8'h00,  -1,  48, 1, 0};
        vecs[10] = '{200, 8'h80,  -1, 8'h00,   7,  48, 0, 0};
        vecs[11] = '{  0, 8'h01,  -1, 8'h00,  -1, 128, 0, 0};
        vecs[12] = '{128, 8'hFE,  -1, 8'h00,  -1,   1, 0, 0};
        vecs[13] = '{ -1, 8'h00,  -1, 8'h00,  -1, 254, 1, 0};
        vecs[14] = '{255, 8'hC8,  -1, 8'h00,   0, 254, 1, 0};
        vecs[15] = '{ -1, 8'h00,  -1, 8'h00,  -1, 254, 1, 0};
        vecs[16] = '{ -1, 8'h00,  -1, 8'h00,  -1, 200, 1, 0};

        // ---- Reset held two clocks with en and sample_valid active ----------
        rst          = 1'b1;
        en           = 1'b1;
        en2          = 1'b0;
        sample       = 8'hAA;
        sample_valid = 1'b1;
        clr_flags    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_t", int'(t1), 0);
            check("rst_pwm", int'(pwm1), 0);
            check("rst_sreq", int'(sreq1), 0);
            check("rst_underrun", int'(ur1), 0);
            check("rst_overrun", int'(ov1), 0);
        end

        // ---- Idle after reset ----------------------------------------------
        rst          = 1'b0;
        en           = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'hxx;
        for (int i = 0; i < 3; i++) tick();
        check("idle_pwm", int'(pwm1), 0);
        check("idle_t", int'(t1), 0);
        hi_acc  = 0;
        len_acc = 0;

        // ---- Table-driven periods (dut1, DIV=1) -----------------------------
        en = 1'b1;
        foreach (vecs[v]) begin
            t_model = (t_model + 1) % 16;
            push_exp(vecs[v].exp_hi, t_model, vecs[v].exp_ur, vecs[v].exp_ov);
            for (int s = 0; s < 256; s++) begin
                sample_valid = (s == vecs[v].ev0_step) || (s == vecs[v].ev1_step);
                if (s == vecs[v].ev1_step)      sample = vecs[v].ev1_val;
                else if (s == vecs[v].ev0_step) sample = vecs[v].ev0_val;
                else                            sample = 8'hxx;
                clr_flags = (s == vecs[v].clr_step);
                tick();
            end
        end
        sample_valid = 1'b0;
        clr_flags    = 1'b0;

        // ---- Drop en at step 100, clear flags while idle, restart -----------
        // active is 0xC8 here; a sample 0x90 is queued at step 0.
        for (int s = 0; s < 100; s++) begin
            sample_valid = (s == 0);
            sample       = (s == 0) ? 8'h90 : 8'hxx;
            tick();
        end
        sample_valid = 1'b0;
        check("pwm_high_before_drop", int'(pwm1), 1);
        en = 1'b0;
        tick();
        check("drop_pwm", int'(pwm1), 0);
        check("drop_sreq", int'(sreq1), 0);
        check("drop_t_held", int'(t1), 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tick();
        check("clr_underrun", int'(ur1), 0);
        check("clr_overrun", int'(ov1), 0);
        check("idle_t_held", int'(t1), 1);
        hi_acc  = 0;
        len_acc = 0;
        // Restart: a full 256-clock period with the old duty 0xC8 proves step 0.
        push_exp(200, 2, 0, 0);
        en = 1'b1;
        for (int s = 0; s < 256; s++) tick();

        // ---- Reset mid-period, then restart with en held --------------------
        for (int s = 0; s < 50; s++) tick();
        rst = 1'b1;
        tick();
        check("midrst_t", int'(t1), 0);
        check("midrst_pwm", int'(pwm1), 0);
        check("midrst_sreq", int'(sreq1), 0);
        check("midrst_underrun", int'(ur1), 0);
        rst     = 1'b0;
        hi_acc  = 0;
        len_acc = 0;
        // active was cleared by reset and nothing arrives: duty 0, underrun.
        push_exp(0, 1, 1, 0);
        for (int s = 0; s < 256; s++) tick();
        check("scoreboard_drained", sb.size(), 0);

        // ---- dut2: DIV=3 period and duty scaling ----------------------------
        en  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en2 = 1'b1;
        highs = 0;
        for (n = 1; n < 2000; n++) begin
            sample_valid = (n == 6);
            sample       = (n == 6) ? 8'h40 : 8'hxx;
            tick();
            highs += int'(pwm2);
            if (sreq2) break;
        end
        sample_valid = 1'b0;
        check("div3_first_period_len", n, 768);
        check("div3_first_period_highs", highs, 0);
        check("div3_t_after_first", int'(t2), 1);
        $display("div3 period 1: len=%0d highs=%0d t=%0d", n, highs, t2);
        highs = 0;
        for (m = 1; m < 2000; m++) begin
            tick();
            highs += int'(pwm2);
            if (sreq2) break;
        end
        check("div3_second_period_len", m, 768);
        check("div3_second_period_highs", highs, 192);
        check("div3_t_after_second", int'(t2), 2);
        check("div3_underrun", int'(ur2), 1);
        check("div3_overrun", int'(ov2), 0);
        $display("div3 period 2: len=%0d highs=%0d t=%0d", m, highs, t2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
